regfile_wb_sched: RTL and testbench

Writeback scheduler and scoreboard for the 32-entry integer register file. It shares the single register-file write port between the ALU and load/store writeback sources using round-robin arbitration. It tracks in-flight destination registers and stalls issue on RAW/WAW hazards. It sits between the execute/LSU stages and the register file write port.

---
 rtl/regsched_pkg.sv | 12 +
 rtl/regfile_wb_sched_if.sv | 38 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/regfile_wb_sched.sv | 54 +++++
 tb/tb_regfile_wb_sched.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/regsched_pkg.sv
// regsched_pkg: shared types and sizes for the writeback scheduler.
// Change D_WIDTH here to resize the writeback datapath.
package regsched_pkg;
  localparam int D_WIDTH = 32;
  localparam int REG_CNT = 32;
  localparam int REG_AW = 5;
  typedef enum logic {WB_ALU, WB_LSU} wb_src_e;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [D_WIDTH-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: writeback, issue and register-file port bundle.
// REGSCHED_BYPASS_EN adds the byp_rs1/byp_rs2 forwarding flags.
interface regfile_wb_sched_if;
  import regsched_pkg::*;
  logic alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [REG_AW-1:0] alu_rd, lsu_rd;
  logic [D_WIDTH-1:0] alu_data, lsu_data;
  logic iss_valid, iss_wr, iss_stall;
  logic [REG_AW-1:0] iss_rs1, iss_rs2, iss_rd;
  logic rf_str;
  logic [REG_AW-1:0] rf_rd;
  logic [D_WIDTH-1:0] rf_wdat;
  logic [REG_CNT-1:0] busy_vec;
`ifdef REGSCHED_BYPASS_EN
  logic byp_rs1, byp_rs2;
  modport slave (
    input alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input iss_valid, iss_wr, iss_rs1, iss_rs2, iss_rd,
    output alu_ready, lsu_ready, iss_stall, rf_str, rf_rd, rf_wdat, busy_vec, byp_rs1, byp_rs2
  );
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_wr, iss_rs1, iss_rs2, iss_rd,
    input alu_ready, lsu_ready, iss_stall, rf_str, rf_rd, rf_wdat, busy_vec, byp_rs1, byp_rs2
  );
`else
  modport slave (
    input alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input iss_valid, iss_wr, iss_rs1, iss_rs2, iss_rd,
    output alu_ready, lsu_ready, iss_stall, rf_str, rf_rd, rf_wdat, busy_vec
  );
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_wr, iss_rs1, iss_rs2, iss_rd,
    input alu_ready, lsu_ready, iss_stall, rf_str, rf_rd, rf_wdat, busy_vec
  );
`endif
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; pointer moves only on contention.
module rr_arb2
  import regsched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  wb_src_e ptr, ptr_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= WB_LSU;
    else ptr <= ptr_nxt;
  always_comb begin
    gnt = req;
    ptr_nxt = ptr;
    if (&req) begin
      gnt = (ptr == WB_LSU) ? 2'b10 : 2'b01;
      ptr_nxt = (ptr == WB_LSU) ? WB_ALU : WB_LSU;
    end
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: arbitrates ALU/LSU onto the register-file write port and stalls issue on hazards.
// REGSCHED_BYPASS_EN masks the register retiring this cycle from RAW stalls and flags forwarding.
module regfile_wb_sched
  import regsched_pkg::*;
(
  input logic clk,
  input logic rst_n,
  regfile_wb_sched_if.slave bus
);
  logic [1:0] gnt;
  wb_req_t sel;
  logic [REG_CNT-1:0] busy, busy_nxt, set_m, clr_m, raw_m;
  rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req({bus.lsu_valid, bus.alu_valid}), .gnt(gnt));
  assign bus.alu_ready = gnt[WB_ALU];
  assign bus.lsu_ready = gnt[WB_LSU];
  assign bus.busy_vec = busy;
  always_comb sel = gnt[WB_LSU] ? wb_req_t'{rd: bus.lsu_rd, data: bus.lsu_data}
                                : wb_req_t'{rd: bus.alu_rd, data: bus.alu_data};
  // rd==0 grants still consume the slot but never strobe the register file
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rf_str <= 1'b0;
      bus.rf_rd <= '0;
      bus.rf_wdat <= '0;
    end else begin
      bus.rf_str <= |gnt && sel.rd != '0;
      if (|gnt) begin
        bus.rf_rd <= sel.rd;
        bus.rf_wdat <= sel.data;
      end
    end
  always_comb begin
    clr_m = bus.rf_str ? REG_CNT'(1) << bus.rf_rd : '0;
`ifdef REGSCHED_BYPASS_EN
    raw_m = busy & ~clr_m;
`else
    raw_m = busy;
`endif
  end
  assign bus.iss_stall = bus.iss_valid &&
    (raw_m[bus.iss_rs1] || raw_m[bus.iss_rs2] || (bus.iss_wr && busy[bus.iss_rd]));
  // applying set after clear lets a same-cycle reissue keep the register busy
  always_comb begin
    set_m = (bus.iss_valid && !bus.iss_stall && bus.iss_wr) ? REG_CNT'(1) << bus.iss_rd : '0;
    busy_nxt = ((busy & ~clr_m) | set_m) & ~REG_CNT'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
`ifdef REGSCHED_BYPASS_EN
  assign bus.byp_rs1 = bus.rf_str && bus.iss_rs1 == bus.rf_rd;
  assign bus.byp_rs2 = bus.rf_str && bus.iss_rs2 == bus.rf_rd;
`endif
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed bench with a writeback scoreboard for regfile_wb_sched.
module tb_regfile_wb_sched;
  import regsched_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic m_ptr = 1'b1;
  wb_req_t exp_q[$];
  regfile_wb_sched_if bus();
  regfile_wb_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                    input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic ga, gl;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ld;
    ga = av && (!lv || !m_ptr);
    gl = lv && (!av || m_ptr);
    if (av && lv) m_ptr = !m_ptr;
    @(negedge clk);
    chk("alu_ready", 64'(bus.alu_ready), 64'(ga));
    chk("lsu_ready", 64'(bus.lsu_ready), 64'(gl));
    if (ga && ard != 0) exp_q.push_back('{rd: ard, data: ad});
    if (gl && lrd != 0) exp_q.push_back('{rd: lrd, data: ld});
    tick();
    bus.alu_valid = 0;
    bus.lsu_valid = 0;
  endtask

  task automatic iss(input logic v, input logic w, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.iss_valid = v; bus.iss_wr = w; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2; bus.iss_rd = rd;
  endtask

  always @(negedge clk)
    if (rst_n && bus.rf_str) begin
      if (exp_q.size() == 0) chk("wb_unexpected_str", 64'(bus.rf_rd), 64'h100);
      else begin
        wb_req_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(bus.rf_rd), 64'(e.rd));
        chk("wb_data", 64'(bus.rf_wdat), 64'(e.data));
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    iss(0, 0, 0, 0, 0);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_str", 64'(bus.rf_str), 0);
    chk("rst_rd", 64'(bus.rf_rd), 0);
    chk("rst_wdat", 64'(bus.rf_wdat), 0);
    chk("rst_busy", 64'(bus.busy_vec), 0);
    chk("rst_stall", 64'(bus.iss_stall), 0);
    tick();
    rst_n = 1;
    tick();
    // single ALU writeback, latency one
    wb(1, 5, 32'hDEADBEEF, 0, 0, 0);
    tick();
    // four contended cycles: LSU, ALU, LSU, ALU
    for (int i = 0; i < 4; i++) wb(1, 5'(10 + i), 32'hA000 + i, 1, 5'(20 + i), 32'hB000 + i);
    tick();
    @(negedge clk);
    chk("busy_after_wb", 64'(bus.busy_vec), 0);
    tick();
    // RAW hazard on x7
    iss(1, 1, 0, 0, 7);
    @(negedge clk);
    chk("iss7_nostall", 64'(bus.iss_stall), 0);
    tick();
    iss(1, 0, 7, 0, 0);
    @(negedge clk);
    chk("raw_stall", 64'(bus.iss_stall), 1);
    chk("busy_x7", 64'(bus.busy_vec), 64'h80);
    tick();
    @(negedge clk);
    chk("raw_stall_hold", 64'(bus.iss_stall), 1);
    tick();
    wb(1, 7, 32'h77, 0, 0, 0);
    @(negedge clk);
`ifdef REGSCHED_BYPASS_EN
    chk("raw_stall_str", 64'(bus.iss_stall), 0);
    chk("byp_rs1", 64'(bus.byp_rs1), 1);
    chk("byp_rs2", 64'(bus.byp_rs2), 0);
`else
    chk("raw_stall_str", 64'(bus.iss_stall), 1);
`endif
    chk("busy_x7_str", 64'(bus.busy_vec), 64'h80);
    tick();
    @(negedge clk);
    chk("raw_release", 64'(bus.iss_stall), 0);
    chk("busy_clear", 64'(bus.busy_vec), 0);
    tick();
    // x0 never tracked nor written; contended rd0 still moves the pointer
    iss(1, 1, 0, 0, 0);
    @(negedge clk);
    chk("x0_stall", 64'(bus.iss_stall), 0);
    tick();
    iss(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0_busy", 64'(bus.busy_vec), 0);
    tick();
    wb(1, 0, 32'h1111, 0, 0, 0);
    wb(0, 0, 0, 1, 0, 32'h2222);
    wb(1, 0, 32'h3333, 1, 0, 32'h4444);
    wb(1, 9, 32'h9999, 1, 11, 32'hBBBB);
    tick();
    @(negedge clk);
    chk("x0_busy2", 64'(bus.busy_vec), 0);
    tick();
    // clear and set of x3 in the same cycle
    wb(1, 3, 32'h33, 0, 0, 0);
    iss(1, 1, 0, 0, 3);
    @(negedge clk);
    chk("x3_set_nostall", 64'(bus.iss_stall), 0);
    tick();
    @(negedge clk);
    chk("x3_busy", 64'(bus.busy_vec), 64'h8);
    chk("x3_waw_stall", 64'(bus.iss_stall), 1);
    tick();
    iss(0, 0, 0, 0, 0);
    wb(0, 0, 0, 1, 3, 32'h34);
    tick();
    @(negedge clk);
    chk("x3_clear", 64'(bus.busy_vec), 0);
    tick();
    // reset mid-operation
    iss(1, 1, 0, 0, 4);
    tick();
    iss(1, 1, 0, 0, 7);
    tick();
    iss(0, 0, 0, 0, 0);
    bus.alu_valid = 1; bus.alu_rd = 12; bus.alu_data = 32'hC;
    bus.lsu_valid = 1; bus.lsu_rd = 13; bus.lsu_data = 32'hD;
    @(negedge clk);
    chk("busy_90", 64'(bus.busy_vec), 64'h90);
    @(posedge clk);
    #1;
    chk("pend_str", 64'(bus.rf_str), 1);
    #1;
    rst_n = 0;
    bus.alu_valid = 0;
    bus.lsu_valid = 0;
    #1;
    chk("mid_rst_str", 64'(bus.rf_str), 0);
    chk("mid_rst_busy", 64'(bus.busy_vec), 0);
    chk("mid_rst_rd", 64'(bus.rf_rd), 0);
    tick();
    rst_n = 1;
    m_ptr = 1'b1;
    tick();
    wb(1, 14, 32'hE, 1, 15, 32'hF);
    wb(1, 16, 32'h10, 1, 17, 32'h11);
    repeat (2) tick();
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
